// File: rtl/accumulator.sv
// rtl/accumulator.sv - signed integrate-and-dump accumulator for one GNSS correlator arm
// Sums +/- carrier-mix magnitude per sample strobe; a dump publishes the sum and seeds the next one.
module accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int MAG_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_enable,
  input  logic                 code,
  input  logic                 carrier_mix_sign,
  input  logic [MAG_WIDTH-1:0] carrier_mix_mag,
  input  logic                 dump_enable,
  output logic [ACC_WIDTH-1:0] accumulation
);

  logic [ACC_WIDTH-1:0] r_accum;
  logic [ACC_WIDTH-1:0] r_accumulation;

  logic                 w_match;
  logic [ACC_WIDTH-1:0] w_mag_ext;
  logic [ACC_WIDTH-1:0] w_contrib;
  logic [ACC_WIDTH-1:0] w_sum;

  // Chip and carrier sign agree -> the sample correlates positively.
  assign w_match   = (code == carrier_mix_sign);
  assign w_mag_ext = {{(ACC_WIDTH-MAG_WIDTH){1'b0}}, carrier_mix_mag};
  assign w_contrib = w_match ? w_mag_ext : (~w_mag_ext + 1'b1);
  assign w_sum     = r_accum + w_contrib;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_accum        <= '0;
      r_accumulation <= '0;
    end else if (sample_enable) begin
      if (dump_enable) begin
        // Dump-cycle sample opens the next integration so nothing is lost.
        r_accumulation <= r_accum;
        r_accum        <= w_contrib;
      end else begin
        r_accum <= w_sum;
      end
    end
  end

  assign accumulation = r_accumulation;

endmodule

// File: tb/tb_accumulator.sv
// tb/tb_accumulator.sv - directed self-checking bench for accumulator
module tb_accumulator;

  logic        clk;
  logic        rst;
  logic        sample_enable;
  logic        code;
  logic        carrier_mix_sign;
  logic [2:0]  carrier_mix_mag;
  logic        dump_enable;
  logic [15:0] accumulation;

  int n_chk;
  int n_err;

  accumulator #(.ACC_WIDTH(16), .MAG_WIDTH(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .sample_enable    (sample_enable),
    .code             (code),
    .carrier_mix_sign (carrier_mix_sign),
    .carrier_mix_mag  (carrier_mix_mag),
    .dump_enable      (dump_enable),
    .accumulation     (accumulation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One-clock sample strobe; outputs are observed at the following falling edge.
  task automatic strobe(input logic c, input logic s, input logic [2:0] m, input logic d);
    @(negedge clk);
    sample_enable    = 1'b1;
    code             = c;
    carrier_mix_sign = s;
    carrier_mix_mag  = m;
    dump_enable      = d;
    @(negedge clk);
    sample_enable = 1'b0;
    dump_enable   = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    sample_enable = 1'b0;
    code = 1'b0;
    carrier_mix_sign = 1'b0;
    carrier_mix_mag = 3'd0;
    dump_enable = 1'b0;

    // Reset held with random activity
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_enable    = 1'($urandom_range(0, 1));
      code             = 1'($urandom_range(0, 1));
      carrier_mix_sign = 1'($urandom_range(0, 1));
      carrier_mix_mag  = 3'($urandom_range(0, 7));
      dump_enable      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_hold", accumulation, 16'h0000);
    end
    rst = 1'b0;
    sample_enable = 1'b0;
    dump_enable = 1'b0;
    strobe(1'b1, 1'b1, 3'd0, 1'b1);
    check("reset_first_dump", accumulation, 16'h0000);

    // Positive integration: 4*3 + 2*1 - 5*2 = 4
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 2; i++) strobe(1'b1, 1'b1, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 3'd2, 1'b0);
    check("no_dump_holds", accumulation, 16'h0000);
    strobe(1'b1, 1'b1, 3'd1, 1'b1);
    check("pos_dump", accumulation, 16'h0004);
    strobe(1'b1, 1'b1, 3'd0, 1'b1);
    check("carry_dump", accumulation, 16'h0001);

    // Sign table cancels to zero
    strobe(1'b1, 1'b1, 3'd5, 1'b0);
    strobe(1'b0, 1'b0, 3'd5, 1'b0);
    strobe(1'b1, 1'b0, 3'd5, 1'b0);
    strobe(1'b0, 1'b1, 3'd5, 1'b0);
    check("sign_hold", accumulation, 16'h0001);
    strobe(1'b0, 1'b1, 3'd0, 1'b1);
    check("sign_table", accumulation, 16'h0000);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 3'd7, 1'b0);
    strobe(1'b1, 1'b0, 3'd0, 1'b1);
    check("neg_28", accumulation, 16'hFFE4);

    // Gating: activity without sample_enable must be ignored
    strobe(1'b1, 1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample_enable    = 1'b0;
      code             = 1'(i);
      carrier_mix_sign = 1'(i >> 1);
      carrier_mix_mag  = 3'(7 - i);
      dump_enable      = 1'b1;
    end
    @(negedge clk);
    dump_enable = 1'b0;
    check("gate_hold", accumulation, 16'hFFE4);
    strobe(1'b0, 1'b0, 3'd0, 1'b1);
    check("gate_dump", accumulation, 16'h0006);

    // Back-to-back dumps show single preceding contributions
    strobe(1'b0, 1'b1, 3'd3, 1'b1);
    check("b2b_dump_a", accumulation, 16'h0000);
    strobe(1'b1, 1'b1, 3'd0, 1'b1);
    check("b2b_dump_b", accumulation, 16'hFFFD);

    // Wrap-around: 4682 * 7 = 32774 -> 0x8006
    for (int i = 0; i < 4682; i++) strobe(1'b0, 1'b0, 3'd7, 1'b0);
    strobe(1'b1, 1'b1, 3'd0, 1'b1);
    check("wrap", accumulation, 16'h8006);

    // Reset priority over a simultaneous dump strobe
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1, 3'd5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sample_enable = 1'b1;
    dump_enable = 1'b1;
    code = 1'b1;
    carrier_mix_sign = 1'b1;
    carrier_mix_mag = 3'd7;
    @(negedge clk);
    rst = 1'b0;
    sample_enable = 1'b0;
    dump_enable = 1'b0;
    check("rst_prio", accumulation, 16'h0000);
    strobe(1'b1, 1'b1, 3'd2, 1'b0);
    strobe(1'b0, 1'b0, 3'd3, 1'b0);
    strobe(1'b1, 1'b0, 3'd0, 1'b1);
    check("post_rst_dump", accumulation, 16'h0005);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
